// File: rtl/cva6_mem_responder.sv
// Memory responder model for the LSU: in-order request queue with fixed latency,
// stall back-pressure on retirement, and a small word-addressed backing store.
module cva6_mem_responder #(
  parameter int NUM_WORDS = 8,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [31:0]               req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      stall_i,
  output logic                      load_mem_resp_o,
  output logic                      store_mem_resp_o,
  output logic [31:0]               rdata_o,
  output logic [NUM_WORDS*32-1:0]   mem_o
);
  localparam int IW   = $clog2(NUM_WORDS);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          we;
    logic [IW-1:0] idx;
    logic [31:0]   wdata;
    logic [2:0]    cd;
  } entry_t;

  entry_t [DEPTH-1:0]        q_q;
  logic   [DEPTH-1:0]        vld_q;
  logic   [PW-1:0]           head_q, tail_q;
  logic   [CNTW-1:0]         cnt_q;
  logic   [NUM_WORDS-1:0][31:0] mem_q;

  entry_t head;
  logic   accept, retire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  // Ready looks only at the registered count, so a full queue stays closed
  // for the cycle in which its head retires.
  assign req_ready_o = rst_ni && (cnt_q < CNTW'(DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign head        = q_q[head_q];
  assign retire      = vld_q[head_q] && (head.cd == 3'd0) && !stall_i;

  assign load_mem_resp_o  = retire && !head.we;
  assign store_mem_resp_o = retire && head.we;
  assign rdata_o          = load_mem_resp_o ? mem_q[head.idx] : 32'd0;
  assign mem_o            = mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (vld_q[i] && q_q[i].cd != 3'd0) q_q[i].cd <= q_q[i].cd - 3'd1;
      if (retire) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_inc(head_q);
        if (head.we) mem_q[head.idx] <= head.wdata;
      end
      // Accept never targets the retiring slot: accept requires a non-full queue.
      if (accept) begin
        q_q[tail_q]   <= '{we: req_we_i, idx: req_addr_i[IW+1:2],
                           wdata: req_wdata_i, cd: 3'(LATENCY - 1)};
        vld_q[tail_q] <= 1'b1;
        tail_q        <= ptr_inc(tail_q);
      end
      case ({accept, retire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_cva6_mem_responder.sv
// Directed bench for cva6_mem_responder at default parameters (8 words, latency 2, depth 2).
module tb_cva6_mem_responder;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        stall_i;
  logic        load_mem_resp_o, store_mem_resp_o;
  logic [31:0] rdata_o;
  logic [255:0] mem_o;

  int total = 0;
  int bad   = 0;

  cva6_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_i(stall_i),
    .load_mem_resp_o(load_mem_resp_o), .store_mem_resp_o(store_mem_resp_o),
    .rdata_o(rdata_o), .mem_o(mem_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = d;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; stall_i = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready_o); end
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b exp=00", {load_mem_resp_o, store_mem_resp_o}); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
    total++; if (mem_o !== 256'h0) begin bad++; $display("FAIL rst_mem got=%h exp=0", mem_o); end
    rst_ni = 1'b1; #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_store();
    drive(1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (store_mem_resp_o !== 1'b0) begin bad++; $display("FAIL store_early got=%b exp=0", store_mem_resp_o); end
    tick();
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b01) begin bad++; $display("FAIL store_pulse got=%b exp=01", {load_mem_resp_o, store_mem_resp_o}); end
    tick();
    total++; if (store_mem_resp_o !== 1'b0) begin bad++; $display("FAIL store_after got=%b exp=0", store_mem_resp_o); end
    total++; if (mem_o[64 +: 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL store_mem2 got=%h exp=deadbeef", mem_o[64 +: 32]); end
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b1, 32'h4, 32'h11);
    tick(); drive(1'b1, 1'b0, 32'h4, 32'hFFFF_FFFF);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (store_mem_resp_o !== 1'b1) begin bad++; $display("FAIL raw_store got=%b exp=1", store_mem_resp_o); end
    tick();
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b10) begin bad++; $display("FAIL raw_load got=%b exp=10", {load_mem_resp_o, store_mem_resp_o}); end
    total++; if (rdata_o !== 32'h11) begin bad++; $display("FAIL raw_rdata got=%h exp=11", rdata_o); end
    tick();
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL raw_rdata_idle got=%h exp=0", rdata_o); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 32'h8, 32'h0);            // A: load word 2
    tick();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready_o); end
    drive(1'b1, 1'b1, 32'hC, 32'hA5);           // B: store word 3
    tick();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", req_ready_o); end
    total++; if (load_mem_resp_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_resp_a got=%b/%h exp=1/deadbeef", load_mem_resp_o, rdata_o); end
    drive(1'b1, 1'b0, 32'hC, 32'h0);            // C: load word 3, held while full
    tick();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready2 got=%b exp=1", req_ready_o); end
    total++; if (store_mem_resp_o !== 1'b1) begin bad++; $display("FAIL b2b_resp_b got=%b exp=1", store_mem_resp_o); end
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b00) begin bad++; $display("FAIL b2b_gap got=%b exp=00", {load_mem_resp_o, store_mem_resp_o}); end
    tick();
    total++; if (load_mem_resp_o !== 1'b1 || rdata_o !== 32'hA5) begin bad++; $display("FAIL b2b_resp_c got=%b/%h exp=1/a5", load_mem_resp_o, rdata_o); end
    tick();
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b00) begin bad++; $display("FAIL b2b_done got=%b exp=00", {load_mem_resp_o, store_mem_resp_o}); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h77);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (store_mem_resp_o !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b exp=0", i, store_mem_resp_o); end
      if (i < 3) tick();
    end
    stall_i = 1'b0; #1;
    total++; if (store_mem_resp_o !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", store_mem_resp_o); end
    tick();
    total++; if (store_mem_resp_o !== 1'b0 || mem_o[128 +: 32] !== 32'h77) begin bad++; $display("FAIL stall_mem got=%b/%h exp=0/77", store_mem_resp_o, mem_o[128 +: 32]); end
  endtask

  task automatic test_idle_inputs();
    drive(1'b0, 1'b1, 32'h8, 32'h1234_5678);
    tick(); tick(); tick();
    total++; if (mem_o[64 +: 32] !== 32'hDEADBEEF || store_mem_resp_o !== 1'b0) begin bad++; $display("FAIL idle_noeffect got=%h/%b exp=deadbeef/0", mem_o[64 +: 32], store_mem_resp_o); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'h18, 32'h66);
    tick(); drive(1'b1, 1'b1, 32'h1C, 32'h99);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_ni = 1'b0; #1;
    total++; if (mem_o !== 256'h0 || req_ready_o !== 1'b0) begin bad++; $display("FAIL midrst_clear got=%h/%b exp=0/0", mem_o, req_ready_o); end
    total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b00) begin bad++; $display("FAIL midrst_resp got=%b exp=00", {load_mem_resp_o, store_mem_resp_o}); end
    tick(); rst_ni = 1'b1;
    tick();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", req_ready_o); end
    for (int i = 0; i < 3; i++) begin
      total++; if ({load_mem_resp_o, store_mem_resp_o} !== 2'b00 || mem_o !== 256'h0) begin bad++; $display("FAIL midrst_quiet%0d got=%b/%h exp=00/0", i, {load_mem_resp_o, store_mem_resp_o}, mem_o); end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'h0, 32'h5A);
    tick(); drive(1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF);
    tick(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (store_mem_resp_o !== 1'b1) begin bad++; $display("FAIL wrap_store got=%b exp=1", store_mem_resp_o); end
    tick();
    total++; if (load_mem_resp_o !== 1'b1 || rdata_o !== 32'h5A) begin bad++; $display("FAIL wrap_load got=%b/%h exp=1/5a", load_mem_resp_o, rdata_o); end
    tick();
    total++; if (mem_o !== {224'h0, 32'h5A}) begin bad++; $display("FAIL wrap_mem got=%h exp=5a in word0 only", mem_o); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_store_load();
    test_back_to_back();
    test_stall();
    test_idle_inputs();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cva6_mem_responder.md
CVA6_MEM_RESPONDER -- requirements
Module: cva6_mem_responder

Interface
REQ-001 Parameter NUM_WORDS, default 8, backing-memory depth in 32-bit words (power of two, 2..32).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response pulse (1..7).
REQ-003 Parameter DEPTH, default 2, maximum outstanding requests (1..4).
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 req_valid_i  input  1  LSU presents a memory request.
REQ-007 req_ready_o  output  1  responder accepts a request this cycle.
REQ-008 req_we_i  input  1  1 = store (SW), 0 = load (LW).
REQ-009 req_addr_i  input  32  byte address; word index = addr[log2(NUM_WORDS)+1:2], other bits ignored.
REQ-010 req_wdata_i  input  32  store data.
REQ-011 stall_i  input  1  holds back response retirement (models memory back-pressure).
REQ-012 load_mem_resp_o  output  1  one-cycle load-complete pulse.
REQ-013 store_mem_resp_o  output  1  one-cycle store-complete pulse.
REQ-014 rdata_o  output  32  load data, valid only while load_mem_resp_o = 1, else 0.
REQ-015 mem_o  output  NUM_WORDS*32  flattened memory contents, word 0 in bits [31:0].

Function
REQ-016 Handshake: request accepted on a rising edge where req_valid_i && req_ready_o are both 1.
REQ-017 req_ready_o = 1 iff outstanding count < DEPTH; combinational from the count only, not from the current-cycle retirement.
REQ-018 Accepted requests enter an in-order queue entry {we, index, wdata, countdown}; countdown loads LATENCY-1.
REQ-019 Every valid entry's nonzero countdown decrements by 1 each cycle, in parallel, independent of stall_i; it saturates at 0.
REQ-020 Head entry retires in a cycle where its countdown = 0 and stall_i = 0.
REQ-021 Response pulse (load_mem_resp_o or store_mem_resp_o per we) is asserted combinationally during the retire cycle.
REQ-022 Latency is exactly LATENCY cycles after the accepting edge when there is no stall and no older entry.
REQ-023 At most one response per cycle; responses follow acceptance order.
REQ-024 Store retirement writes wdata to mem[index] at the retiring edge.
REQ-025 Load retirement drives rdata_o = mem[index] as of that cycle, so an older store to the same index is visible.
REQ-026 Simultaneous accept and retire in one cycle: count is unchanged, and the new entry is appended behind the remaining entries.
REQ-027 Full (count = DEPTH): req_ready_o = 0 even when the head retires this cycle; the request is accepted next cycle.
REQ-028 Empty: no response outputs assert, and req_ready_o = 1.
REQ-029 Queue pointers are modulo DEPTH and wrap without loss or duplication.
REQ-030 Requests with req_valid_i = 0 have no effect; the address, data and we inputs are ignored.
REQ-031 load_mem_resp_o and store_mem_resp_o are never both 1.

Reset
REQ-032 rst_ni = 0 asynchronously clears the queue, count, pointers and all memory words.
REQ-033 During reset, req_ready_o = 0; all response outputs, rdata_o and mem_o are 0.
REQ-034 Reset asserted mid-operation discards all outstanding requests with no response pulse.
REQ-035 First acceptance is possible on the first rising edge after rst_ni deasserts (req_ready_o = 1 once rst_ni = 1).

Verification
REQ-036 LATENCY=2: store addr 0x8, data 0xDEADBEEF accepted at edge T -> store_mem_resp_o high in cycle T+2 only; mem_o word 2 = 0xDEADBEEF after that edge.
REQ-037 Store 0x11 to addr 0x4, then a load from 0x4 accepted the next cycle -> load pulse at T+3, rdata_o = 0x11.
REQ-038 DEPTH=2: three back-to-back requests -> req_ready_o drops after the second; third accepted one cycle after the first response; three responses in order.
REQ-039 stall_i held high for 4 cycles over a ready head -> no pulse while stalled; response pulse in the first cycle stall_i = 0.
REQ-040 rst_ni pulsed low with 2 entries outstanding -> no responses, mem_o = 0, req_ready_o = 1 one cycle after release.
REQ-041 Load from addr 0x20 with NUM_WORDS=8 -> index wraps to 0, and rdata_o = mem word 0.
